// File: rtl/cntr3_dir_decoder.sv
// Receive-side decoder for the 2-bit mod-3 counter state code.
// It recovers the step direction, tracks net signed position and flags illegal codes.
module cntr3_dir_decoder #(
  parameter int POS_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  input  logic [1:0]       i_state,
  input  logic             i_clear,
  output logic             o_locked,
  output logic             o_step,
  output logic             o_dir,
  output logic             o_hold,
  output logic             o_err,
  output logic [POS_W-1:0] o_pos
);

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    TRACK = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic signed [POS_W-1:0] POS_ONE = POS_W'(1);

  state_t                  state_q, state_d;
  logic [1:0]              prev_q, prev_d;
  logic                    step_q, step_d;
  logic                    dir_q, dir_d;
  logic                    hold_q, hold_d;
  logic                    err_q, err_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic                    legal;

  function automatic logic [1:0] mod3_inc(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  assign legal = (i_state != 2'b11);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
      prev_q  <= 2'b00;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      hold_q  <= 1'b0;
      err_q   <= 1'b0;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      hold_q  <= hold_d;
      err_q   <= err_d;
      pos_q   <= pos_d;
    end
  end

  // Clear overrides any sample arriving in the same cycle.
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = INIT;
    end else if (i_valid) begin
      case (state_q)
        INIT:    if (legal) state_d = TRACK;
        TRACK:   if (!legal) state_d = ERR;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    prev_d = prev_q;
    step_d = 1'b0;
    hold_d = 1'b0;
    dir_d  = dir_q;
    err_d  = err_q;
    pos_d  = pos_q;
    if (i_clear) begin
      pos_d = '0;
      err_d = 1'b0;
    end else if (i_valid) begin
      case (state_q)
        INIT: begin
          if (legal) prev_d = i_state;
        end
        TRACK: begin
          if (!legal) begin
            err_d = 1'b1;
          end else begin
            prev_d = i_state;
            if (i_state == prev_q) begin
              hold_d = 1'b1;
            end else if (i_state == mod3_inc(prev_q)) begin
              step_d = 1'b1;
              dir_d  = 1'b1;
              pos_d  = pos_q + POS_ONE;
            end else begin
              // Any other legal jump is necessarily one step down.
              step_d = 1'b1;
              dir_d  = 1'b0;
              pos_d  = pos_q - POS_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_locked = (state_q == TRACK);
  assign o_step   = step_q;
  assign o_dir    = dir_q;
  assign o_hold   = hold_q;
  assign o_err    = err_q;
  assign o_pos    = pos_q;

endmodule

// File: tb/tb_cntr3_dir_decoder.sv
// Bench for cntr3_dir_decoder: directed scenarios plus randomized samples
// checked against an arithmetic position/direction model.
module tb_cntr3_dir_decoder;

  localparam int POS_W = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             i_valid;
  logic [1:0]       i_state;
  logic             i_clear;
  logic             o_locked, o_step, o_dir, o_hold, o_err;
  logic [POS_W-1:0] o_pos;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: mode 0 = no reference, 1 = tracking, 2 = error latched
  int m_mode, m_prev, m_pos, m_dir, m_step, m_hold, m_err;

  cntr3_dir_decoder #(.POS_W(POS_W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_valid  (i_valid),
    .i_state  (i_state),
    .i_clear  (i_clear),
    .o_locked (o_locked),
    .o_step   (o_step),
    .o_dir    (o_dir),
    .o_hold   (o_hold),
    .o_err    (o_err),
    .o_pos    (o_pos)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_pos = 0; m_dir = 0;
    m_step = 0; m_hold = 0; m_err = 0;
  endtask

  task automatic model_cycle(input int v, input int s, input int c);
    int diff;
    m_step = 0;
    m_hold = 0;
    if (c != 0) begin
      m_mode = 0;
      m_pos  = 0;
      m_err  = 0;
    end else if (v != 0) begin
      if (m_mode == 0) begin
        if (s != 3) begin
          m_prev = s;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (s == 3) begin
          m_mode = 2;
          m_err  = 1;
        end else begin
          diff = (s - m_prev + 3) % 3;
          if (diff == 0) m_hold = 1;
          else if (diff == 1) begin
            m_step = 1; m_dir = 1; m_pos = (m_pos + 1) % 256;
          end else begin
            m_step = 1; m_dir = 0; m_pos = (m_pos + 255) % 256;
          end
          m_prev = s;
        end
      end
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".locked"}, 32'(o_locked), 32'(m_mode == 1));
    chk({tag, ".step"},   32'(o_step),   32'(m_step));
    chk({tag, ".dir"},    32'(o_dir),    32'(m_dir));
    chk({tag, ".hold"},   32'(o_hold),   32'(m_hold));
    chk({tag, ".err"},    32'(o_err),    32'(m_err));
    chk({tag, ".pos"},    32'(o_pos),    32'(m_pos));
  endtask

  // Apply one cycle of inputs, then check outputs 1 time unit after the edge.
  task automatic cyc(input string tag, input int v, input int s, input int c);
    i_valid = 1'(v);
    i_state = 2'(s);
    i_clear = 1'(c);
    @(posedge clk);
    #1;
    model_cycle(v, s, c);
    chk_all(tag);
  endtask

  initial begin
    int r, v, s, c, st;
    reset_n = 1'b0;
    i_valid = 1'b0;
    i_state = 2'b00;
    i_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset");
    reset_n = 1'b1;
    cyc("idle", 0, 0, 0);

    // Up-count sequence
    cyc("inc0", 1, 0, 0);
    cyc("inc1", 1, 1, 0);
    cyc("inc2", 1, 2, 0);
    cyc("inc3", 1, 0, 0);
    cyc("inc4", 1, 1, 0);
    chk("inc.pos4", 32'(o_pos), 32'd4);
    cyc("gap", 0, 2, 0);
    cyc("inc5", 1, 2, 0);
    chk("inc.pos5", 32'(o_pos), 32'd5);

    // Asynchronous reset mid-track, checked before the next edge
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk_all("async_rst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Down-count sequence then hold
    cyc("dec0", 1, 0, 0);
    cyc("dec1", 1, 2, 0);
    cyc("dec2", 1, 1, 0);
    cyc("dec3", 1, 0, 0);
    chk("dec.pos", 32'(o_pos), 32'hFD);
    cyc("hold", 1, 0, 0);
    chk("hold.pos", 32'(o_pos), 32'hFD);

    // Illegal code while tracking, ignored samples, clear
    cyc("ill", 1, 3, 0);
    cyc("ign1", 1, 1, 0);
    cyc("ign2", 1, 2, 0);
    cyc("clr", 0, 0, 1);
    chk("clr.err", 32'(o_err), 32'd0);

    // Illegal code before lock does not flag
    cyc("ill_init", 1, 3, 0);
    cyc("lock", 1, 2, 0);

    // Clear collides with a valid step
    cyc("clr_step", 1, 0, 1);
    cyc("relock", 1, 1, 0);
    cyc("after", 1, 2, 0);

    // Position wrap
    cyc("wclr", 0, 0, 1);
    cyc("wlock", 1, 0, 0);
    st = 0;
    for (int i = 0; i < 255; i++) begin
      st = (st + 1) % 3;
      cyc("winc", 1, st, 0);
    end
    chk("wrap.ff", 32'(o_pos), 32'hFF);
    st = (st + 1) % 3;
    cyc("wrap_up", 1, st, 0);
    chk("wrap.00", 32'(o_pos), 32'h00);
    st = (st + 2) % 3;
    cyc("wrap_dn", 1, st, 0);
    chk("wrap.ff2", 32'(o_pos), 32'hFF);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      c = ($urandom_range(0, 39) == 0) ? 1 : 0;
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      r = $urandom_range(0, 24);
      s = (r == 0) ? 3 : $urandom_range(0, 2);
      cyc("rand", v, s, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
